// File: rtl/alu_serial_pkg.sv
// Shared encodings for the digit-serial ALU: operation codes, carry-in
// selects and controller state codes, plus small decode helpers.
package alu_serial_pkg;

    // Operation codes; 5..7 are reserved and leave the flags untouched.
    localparam logic [2:0] ALU_OP_ADD     = 3'd0;
    localparam logic [2:0] ALU_OP_BCD_ADD = 3'd1;
    localparam logic [2:0] ALU_OP_ROL     = 3'd2;
    localparam logic [2:0] ALU_OP_ROR     = 3'd3;
    localparam logic [2:0] ALU_OP_PASS    = 3'd4;

    // Carry-in selects.
    localparam logic [1:0] ALU_CIN_ZERO      = 2'd0;
    localparam logic [1:0] ALU_CIN_ONE       = 2'd1;
    localparam logic [1:0] ALU_CIN_CARRY     = 2'd2;
    localparam logic [1:0] ALU_CIN_CARRY_INV = 2'd3;

    // Controller states.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    function automatic logic alu_op_reserved(input logic [2:0] op);
        return op > ALU_OP_PASS;
    endfunction

    function automatic logic alu_cin_value(input logic [1:0] sel, input logic flag);
        logic val;
        case (sel)
            ALU_CIN_ZERO:  val = 1'b0;
            ALU_CIN_ONE:   val = 1'b1;
            ALU_CIN_CARRY: val = flag;
            default:       val = ~flag;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/alu_digit.sv
// Combinational single-digit slice of the serial ALU.
// Ports:
//   op     - operation code (alu_serial_pkg encodings)
//   a_d    - digit of operand a
//   b_d    - digit of operand b (add operations only)
//   c      - incoming carry / rotate-in bit
//   digit  - result digit
//   c_out  - outgoing carry / rotate-out bit
module alu_digit
    import alu_serial_pkg::*;
#(
    parameter int unsigned DIGIT_W = 4
) (
    input  logic [2:0]         op,
    input  logic [DIGIT_W-1:0] a_d,
    input  logic [DIGIT_W-1:0] b_d,
    input  logic               c,
    output logic [DIGIT_W-1:0] digit,
    output logic               c_out
);

    localparam logic [DIGIT_W:0]   BCD_MAX = (DIGIT_W + 1)'(9);
    localparam logic [DIGIT_W-1:0] BCD_ADJ = DIGIT_W'(6);

    logic [DIGIT_W:0]   sum;
    logic [DIGIT_W-1:0] sum_adj;

    assign sum     = {1'b0, a_d} + {1'b0, b_d} + {{DIGIT_W{1'b0}}, c};
    // Decimal correction wraps modulo the digit width.
    assign sum_adj = sum[DIGIT_W-1:0] + BCD_ADJ;

    always_comb begin
        digit = a_d;
        c_out = c;
        case (op)
            ALU_OP_ADD: begin
                digit = sum[DIGIT_W-1:0];
                c_out = sum[DIGIT_W];
            end
            ALU_OP_BCD_ADD: begin
                if (sum > BCD_MAX) begin
                    digit = sum_adj;
                    c_out = 1'b1;
                end else begin
                    digit = sum[DIGIT_W-1:0];
                    c_out = 1'b0;
                end
            end
            ALU_OP_ROL: begin
                digit = {a_d[DIGIT_W-2:0], c};
                c_out = a_d[DIGIT_W-1];
            end
            ALU_OP_ROR: begin
                digit = {c, a_d[DIGIT_W-1:1]};
                c_out = a_d[0];
            end
            default: begin
                // PASS and reserved codes copy the digit and keep the carry.
                digit = a_d;
                c_out = c;
            end
        endcase
    end

endmodule

// File: rtl/alu_serial.sv
// Digit-serial multi-precision ALU. Processes one DIGIT_W-bit digit per clock
// through a registered carry, with a start/busy/done handshake.
// Ports:
//   clock, reset        - rising-edge clock, synchronous active-high reset
//   start               - operation request, honoured only when idle
//   op, cin_sel         - operation code and carry-in select
//   a, b, a_inv, b_inv  - operands and latch-time inversion controls
//   busy                - operation in flight
//   done                - one-cycle pulse when result/carry/zero update
//   result, carry, zero - last result, persistent carry flag, result==0
module alu_serial
    import alu_serial_pkg::*;
#(
    parameter int unsigned DIGIT_W = 4,
    parameter int unsigned NDIGITS = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       start,
    input  logic [2:0]                 op,
    input  logic [1:0]                 cin_sel,
    input  logic [DIGIT_W*NDIGITS-1:0] a,
    input  logic [DIGIT_W*NDIGITS-1:0] b,
    input  logic                       a_inv,
    input  logic                       b_inv,
    output logic                       busy,
    output logic                       done,
    output logic [DIGIT_W*NDIGITS-1:0] result,
    output logic                       carry,
    output logic                       zero
);

    localparam int unsigned W     = DIGIT_W * NDIGITS;
    localparam int unsigned IDX_W = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NDIGITS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    if (DIGIT_W < 4) begin : g_bad_digit_w
        $error("alu_serial: DIGIT_W must be at least 4 for BCD");
    end
    if (NDIGITS < 1) begin : g_bad_ndigits
        $error("alu_serial: NDIGITS must be at least 1");
    end

    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic [2:0]       op_q, op_d;
    logic             c_q, c_d;
    logic [W-1:0]     work_q, work_d;
    logic [W-1:0]     result_q, result_d;
    logic             carry_q, carry_d;
    logic             zero_q, zero_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [31:0]        dig_lsb;
    logic [DIGIT_W-1:0] slice_a, slice_b, slice_digit;
    logic               slice_cout;
    logic               last_digit;

    assign dig_lsb = 32'(idx_q) * DIGIT_W;
    assign slice_a = a_q[dig_lsb +: DIGIT_W];
    assign slice_b = b_q[dig_lsb +: DIGIT_W];

    // ROR walks from the top digit down; everything else walks upward.
    assign last_digit = (op_q == ALU_OP_ROR) ? (idx_q == '0) : (idx_q == IDX_LAST);

    alu_digit #(
        .DIGIT_W (DIGIT_W)
    ) u_digit (
        .op    (op_q),
        .a_d   (slice_a),
        .b_d   (slice_b),
        .c     (c_q),
        .digit (slice_digit),
        .c_out (slice_cout)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        c_d      = c_q;
        work_d   = work_q;
        result_d = result_q;
        carry_d  = carry_q;
        zero_d   = zero_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d     = a ^ {W{a_inv}};
                    b_d     = b ^ {W{b_inv}};
                    op_d    = op;
                    c_d     = alu_cin_value(cin_sel, carry_q);
                    idx_d   = (op == ALU_OP_ROR) ? IDX_LAST : '0;
                    work_d  = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                work_d[dig_lsb +: DIGIT_W] = slice_digit;
                c_d = slice_cout;
                if (last_digit) begin
                    state_d = ST_DONE;
                    // Flags become visible in the DONE cycle alongside done.
                    if (!alu_op_reserved(op_q)) begin
                        result_d = work_d;
                        carry_d  = slice_cout;
                        zero_d   = (work_d == '0);
                    end
                end else if (op_q == ALU_OP_ROR) begin
                    idx_d = idx_q - IDX_ONE;
                end else begin
                    idx_d = idx_q + IDX_ONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= ALU_OP_ADD;
            c_q      <= 1'b0;
            work_q   <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            c_q      <= c_d;
            work_q   <= work_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            zero_q   <= zero_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign carry  = carry_q;
    assign zero   = zero_q;

endmodule

// File: tb/tb_alu_serial.sv
module tb_alu_serial;
    import alu_serial_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [1:0]  cin_sel;
    logic [15:0] a, b;
    logic        a_inv, b_inv;
    logic        busy, done, carry, zero;
    logic [15:0] result;

    int n_tests = 0;
    int n_fail  = 0;
    int n_done;

    alu_serial #(
        .DIGIT_W (4),
        .NDIGITS (4)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .cin_sel (cin_sel),
        .a       (a),
        .b       (b),
        .a_inv   (a_inv),
        .b_inv   (b_inv),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .carry   (carry),
        .zero    (zero)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Presents a request for one edge, then scrambles the inputs; returns in cycle 1.
    task automatic start_op(input logic [2:0] o, input logic [1:0] cs, input logic [15:0] va,
                            input logic [15:0] vb, input logic ai, input logic bi);
        @(negedge clock);
        op = o; cin_sel = cs; a = va; b = vb; a_inv = ai; b_inv = bi; start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        op = 3'd7; cin_sel = 2'd3; a = ~va; b = ~vb; a_inv = ~ai; b_inv = ~bi;
    endtask

    // Waits for done from cycle 1, checks its cycle, then steps back to idle.
    task automatic finish_op(input string tag);
        int cyc;
        cyc = 0;
        for (int i = 1; i <= 20; i++) begin
            if (done) begin
                cyc = i;
                break;
            end
            @(posedge clock);
            #1;
        end
        check({tag, "_done_cycle"}, cyc, 5);
        @(posedge clock);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [15:0] r, input logic c,
                             input logic z);
        check({tag, "_result"}, {16'h0, result}, {16'h0, r});
        check({tag, "_carry"}, {31'h0, carry}, {31'h0, c});
        check({tag, "_zero"}, {31'h0, zero}, {31'h0, z});
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; op = '0; cin_sel = '0;
        a = '0; b = '0; a_inv = 1'b0; b_inv = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_done", {31'h0, done}, 32'h0);
        check_out("rst", 16'h0000, 1'b0, 1'b1);
        @(negedge clock);
        reset = 1'b0;

        // ADD with full carry ripple, cycle-exact handshake.
        start_op(ALU_OP_ADD, ALU_CIN_ZERO, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
        for (int k = 1; k <= 6; k++) begin
            check($sformatf("add_busy_c%0d", k), {31'h0, busy}, {31'h0, (k <= 5)});
            check($sformatf("add_done_c%0d", k), {31'h0, done}, {31'h0, (k == 5)});
            @(posedge clock);
            #1;
        end
        check_out("add", 16'h0000, 1'b1, 1'b1);

        // Subtract as ADD with inverted b and carry-in one.
        start_op(ALU_OP_ADD, ALU_CIN_ONE, 16'h0005, 16'h0003, 1'b0, 1'b1);
        finish_op("sub1");
        check_out("sub1", 16'h0002, 1'b1, 1'b0);
        start_op(ALU_OP_ADD, ALU_CIN_ONE, 16'h0003, 16'h0005, 1'b0, 1'b1);
        finish_op("sub2");
        check_out("sub2", 16'hFFFE, 1'b0, 1'b0);

        start_op(ALU_OP_BCD_ADD, ALU_CIN_ZERO, 16'h0958, 16'h0047, 1'b0, 1'b0);
        finish_op("bcd1");
        check_out("bcd1", 16'h1005, 1'b0, 1'b0);
        start_op(ALU_OP_BCD_ADD, ALU_CIN_ZERO, 16'h9999, 16'h0001, 1'b0, 1'b0);
        finish_op("bcd2");
        check_out("bcd2", 16'h0000, 1'b1, 1'b1);

        // Flag is 1 from the previous BCD carry.
        start_op(ALU_OP_ROR, ALU_CIN_CARRY, 16'h0001, 16'h0000, 1'b0, 1'b0);
        finish_op("ror");
        check_out("ror", 16'h8000, 1'b1, 1'b0);
        start_op(ALU_OP_ROL, ALU_CIN_ZERO, 16'h8000, 16'h0000, 1'b0, 1'b0);
        finish_op("rol");
        check_out("rol", 16'h0000, 1'b1, 1'b1);

        // PASS keeps c0 as carry; CARRY_INV of flag 1 gives 0.
        start_op(ALU_OP_PASS, ALU_CIN_CARRY_INV, 16'h1234, 16'hFFFF, 1'b1, 1'b0);
        finish_op("pass");
        check_out("pass", 16'hEDCB, 1'b0, 1'b0);

        // Reserved op pulses done but leaves outputs alone.
        start_op(3'd5, ALU_CIN_ONE, 16'h0000, 16'h0000, 1'b0, 1'b0);
        finish_op("rsvd");
        check_out("rsvd", 16'hEDCB, 1'b0, 1'b0);

        // Start held through RUN and DONE is ignored.
        start_op(ALU_OP_ADD, ALU_CIN_ZERO, 16'h0001, 16'h0002, 1'b0, 1'b0);
        start = 1'b1; op = ALU_OP_ADD; cin_sel = ALU_CIN_ZERO;
        a = 16'h0100; b = 16'h0100; a_inv = 1'b0; b_inv = 1'b0;
        n_done = 0;
        for (int k = 1; k <= 5; k++) begin
            if (done) n_done++;
            @(posedge clock);
            #1;
        end
        start = 1'b0;
        check("restart_busy_c6", {31'h0, busy}, 32'h0);
        for (int k = 6; k <= 9; k++) begin
            if (done) n_done++;
            @(posedge clock);
            #1;
        end
        check("restart_done_count", n_done, 1);
        check_out("restart", 16'h0003, 1'b0, 1'b0);

        // Reset in cycle 2 aborts the operation.
        start_op(ALU_OP_ADD, ALU_CIN_ZERO, 16'h1111, 16'h1111, 1'b0, 1'b0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        check("abort_busy", {31'h0, busy}, 32'h0);
        check("abort_done", {31'h0, done}, 32'h0);
        check_out("abort", 16'h0000, 1'b0, 1'b1);
        n_done = 0;
        for (int k = 0; k < 6; k++) begin
            if (done) n_done++;
            @(posedge clock);
            #1;
        end
        check("abort_no_done", n_done, 0);
        start_op(ALU_OP_ADD, ALU_CIN_ZERO, 16'h0002, 16'h0003, 1'b0, 1'b0);
        finish_op("post_abort");
        check_out("post_abort", 16'h0005, 1'b0, 1'b0);

        // Reset and start together: reset wins.
        @(negedge clock);
        reset = 1'b1; start = 1'b1; op = ALU_OP_ADD; a = 16'h0001; b = 16'h0001;
        @(posedge clock);
        #1;
        reset = 1'b0; start = 1'b0;
        check("rst_start_busy", {31'h0, busy}, 32'h0);
        @(posedge clock);
        #1;
        check("rst_start_busy2", {31'h0, busy}, 32'h0);
        check_out("rst_start", 16'h0000, 1'b0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
